// File: rtl/jtkunio_gfx_arb.sv
// Kunio graphics ROM arbiter: three one-entry tile caches (char/scr/obj) sharing
// one SDRAM read port, fixed priority with an anti-starvation override for obj.

module jtkunio_gfx_arb_cache (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] addr,
    input  logic        cs,
    input  logic        wr,
    input  logic [17:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] data,
    output logic        ok,
    output logic        pending
);
    logic [17:0] cache_addr;
    logic        valid;
    logic        hit;

    // reset wins over a completing write so an in-flight rom_ok is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= 1'b0;
            cache_addr <= '0;
            data       <= '0;
        end else if (wr) begin
            valid      <= 1'b1;
            cache_addr <= wr_addr;
            data       <= wr_data;
        end
    end

    assign hit     = valid & (addr == cache_addr);
    assign ok      = hit & cs;
    assign pending = cs & ~hit;
endmodule

module jtkunio_gfx_arb #(
    parameter logic [19:0] CHAR_OFFSET = 20'h00000,
    parameter logic [19:0] SCR_OFFSET  = 20'h04000,
    parameter logic [19:0] OBJ_OFFSET  = 20'h24000,
    parameter logic [5:0]  STARVE      = 6'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] char_addr,
    input  logic        char_cs,
    output logic [31:0] char_data,
    output logic        char_ok,
    input  logic [16:0] scr_addr,
    input  logic        scr_cs,
    output logic [31:0] scr_data,
    output logic        scr_ok,
    input  logic [17:0] obj_addr,
    input  logic        obj_cs,
    output logic [31:0] obj_data,
    output logic        obj_ok,
    output logic [19:0] rom_addr,
    output logic        rom_cs,
    input  logic [31:0] rom_data,
    input  logic        rom_ok
);
    localparam int NUM_CH = 3;
    localparam logic [1:0] CH_CHAR = 2'd0;
    localparam logic [1:0] CH_SCR  = 2'd1;
    localparam logic [1:0] CH_OBJ  = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT1, ST_WAIT} state_t;

    state_t state, state_nx;

    logic [NUM_CH-1:0][17:0] ch_addr;
    logic [NUM_CH-1:0][31:0] ch_data;
    logic [NUM_CH-1:0]       ch_cs, ch_ok, pend;

    logic [1:0]  sel;
    logic [17:0] lat_addr;
    logic [5:0]  starve_cnt;
    logic        win_vld;
    logic [1:0]  win_ch;
    logic [17:0] win_addr;
    logic [19:0] win_off;
    logic        issue, done, obj_busy;

    assign ch_addr = {obj_addr, {1'b0, scr_addr}, {4'b0, char_addr}};
    assign ch_cs   = {obj_cs, scr_cs, char_cs};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        jtkunio_gfx_arb_cache u_cache (
            .clk     (clk),
            .rst     (rst),
            .addr    (ch_addr[i]),
            .cs      (ch_cs[i]),
            .wr      (done && sel == 2'(i)),
            .wr_addr (lat_addr),
            .wr_data (rom_data),
            .data    (ch_data[i]),
            .ok      (ch_ok[i]),
            .pending (pend[i])
        );
    end

    assign char_data = ch_data[CH_CHAR];
    assign scr_data  = ch_data[CH_SCR];
    assign obj_data  = ch_data[CH_OBJ];
    assign char_ok   = ch_ok[CH_CHAR];
    assign scr_ok    = ch_ok[CH_SCR];
    assign obj_ok    = ch_ok[CH_OBJ];

    // a starved obj request jumps ahead of the fixed char > scr > obj order
    always_comb begin
        win_vld = |pend;
        win_ch  = CH_OBJ;
        if (pend[CH_OBJ] && starve_cnt >= STARVE) win_ch = CH_OBJ;
        else if (pend[CH_CHAR])                   win_ch = CH_CHAR;
        else if (pend[CH_SCR])                    win_ch = CH_SCR;
    end

    always_comb begin
        win_off  = OBJ_OFFSET;
        win_addr = ch_addr[CH_OBJ];
        case (win_ch)
            CH_CHAR: begin win_off = CHAR_OFFSET; win_addr = ch_addr[CH_CHAR]; end
            CH_SCR:  begin win_off = SCR_OFFSET;  win_addr = ch_addr[CH_SCR];  end
            default: begin win_off = OBJ_OFFSET;  win_addr = ch_addr[CH_OBJ];  end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // WAIT1 exists so an ok left over from a previous access is never taken
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (win_vld) state_nx = ST_WAIT1;
            ST_WAIT1: state_nx = ST_WAIT;
            ST_WAIT:  if (rom_ok) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rom_cs = state != ST_IDLE;
        issue  = state == ST_IDLE && win_vld;
        done   = state == ST_WAIT && rom_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            sel      <= CH_CHAR;
            lat_addr <= '0;
        end else if (issue) begin
            rom_addr <= win_off + {2'b0, win_addr};
            sel      <= win_ch;
            lat_addr <= win_addr;
        end
    end

    assign obj_busy = rom_cs && sel == CH_OBJ;

    always_ff @(posedge clk) begin
        if (rst || !obj_cs || (issue && win_ch == CH_OBJ))
            starve_cnt <= '0;
        else if (pend[CH_OBJ] && !obj_busy && starve_cnt != 6'h3F)
            starve_cnt <= starve_cnt + 6'd1;
    end
endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
// Randomized/directed bench for jtkunio_gfx_arb against a cache+arbitration
// reference model; a second instance uses a wrapping obj offset.

module tb_jtkunio_gfx_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] char_addr;
    logic [16:0] scr_addr;
    logic [17:0] obj_addr;
    logic        char_cs, scr_cs, obj_cs;
    logic [31:0] rom_data;
    logic        rom_ok;

    logic [31:0] char_data, scr_data, obj_data;
    logic        char_ok, scr_ok, obj_ok, rom_cs;
    logic [19:0] rom_addr;

    logic [31:0] w_char_data, w_scr_data, w_obj_data;
    logic        w_char_ok, w_scr_ok, w_obj_ok, w_rom_cs;
    logic [19:0] w_rom_addr;

    always #5 clk = ~clk;

    jtkunio_gfx_arb dut (
        .clk(clk), .rst(rst),
        .char_addr(char_addr), .char_cs(char_cs), .char_data(char_data), .char_ok(char_ok),
        .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
    );

    jtkunio_gfx_arb #(.OBJ_OFFSET(20'hFFFF0)) dut_w (
        .clk(clk), .rst(rst),
        .char_addr(char_addr), .char_cs(char_cs), .char_data(w_char_data), .char_ok(w_char_ok),
        .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(w_scr_data), .scr_ok(w_scr_ok),
        .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(w_obj_data), .obj_ok(w_obj_ok),
        .rom_addr(w_rom_addr), .rom_cs(w_rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
    );

    int checks = 0;
    int errors = 0;

    // reference model: what each channel's cache holds
    logic [17:0] m_addr [3];
    logic [31:0] m_data [3];
    bit          m_vld  [3];
    int          cnt, p_cnt;

    // stimulus for the next cycle, written by the directed steps
    bit          n_rst, force_ok, stale_en, fix_en;
    bit          n_cs   [3];
    logic [17:0] n_addr [3];
    logic [31:0] fix_data;
    int          sd_delay;

    bit          cur_cs   [3];
    logic [17:0] cur_addr [3];
    bit          exp_cs, p_rst, p_acc;
    logic [19:0] exp_addr, exp_addr_w;
    int          cur_ch, p_ch;
    logic [17:0] cur_a, p_a;
    logic [31:0] p_d;
    int          cs_age, cd;
    logic [19:0] obs_q[$];
    logic [19:0] obs_w_q[$];
    bit          obj_seen;

    function automatic logic [19:0] offs(int ch, bit wrap);
        case (ch)
            0:       return 20'h00000;
            1:       return 20'h04000;
            default: return wrap ? 20'hFFFF0 : 20'h24000;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit          pend [3];
        bit          ok_drv, iss;
        logic [31:0] d;
        logic [31:0] o_dat [3];
        bit          o_ok  [3];
        int          w;
        @(negedge clk);
        if (p_rst) begin
            for (int i = 0; i < 3; i++) begin m_vld[i] = 0; m_addr[i] = '0; m_data[i] = '0; end
        end else if (p_acc) begin
            m_addr[p_ch] = p_a; m_data[p_ch] = p_d; m_vld[p_ch] = 1;
        end
        cnt = p_cnt;

        o_dat[0] = char_data; o_dat[1] = scr_data; o_dat[2] = obj_data;
        o_ok[0]  = char_ok;   o_ok[1]  = scr_ok;   o_ok[2]  = obj_ok;
        chk("rom_cs", 32'(rom_cs), 32'(exp_cs));
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
        chk("w_rom_cs", 32'(w_rom_cs), 32'(exp_cs));
        chk("w_rom_addr", 32'(w_rom_addr), 32'(exp_addr_w));
        chk("starve_cnt", 32'(dut.starve_cnt), 32'(cnt));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ok%0d", i), 32'(o_ok[i]),
                32'(cur_cs[i] && m_vld[i] && cur_addr[i] == m_addr[i]));
            chk($sformatf("data%0d", i), o_dat[i], m_data[i]);
        end

        // SDRAM model: optional stale ok on first cs cycle, data after sd_delay
        cs_age = rom_cs ? cs_age + 1 : 0;
        if (cs_age == 1) begin
            obs_q.push_back(rom_addr);
            obs_w_q.push_back(w_rom_addr);
            if (rom_addr >= 20'h24000) begin
                obj_seen = 1;
                chk("starve_clr", 32'(dut.starve_cnt), 32'd0);
            end
        end
        ok_drv = 0;
        if (cs_age == 1) begin cd = sd_delay; ok_drv = stale_en; end
        else if (cs_age >= 2) begin
            if (cd <= 1) ok_drv = 1; else cd--;
        end
        if (force_ok) ok_drv = 1;
        d = fix_en ? fix_data : $urandom;

        rst = n_rst;
        char_cs = n_cs[0]; scr_cs = n_cs[1]; obj_cs = n_cs[2];
        char_addr = n_addr[0][13:0]; scr_addr = n_addr[1][16:0]; obj_addr = n_addr[2];
        rom_ok = ok_drv; rom_data = d;
        cur_cs = n_cs;
        cur_addr[0] = {4'b0, n_addr[0][13:0]};
        cur_addr[1] = {1'b0, n_addr[1][16:0]};
        cur_addr[2] = n_addr[2];

        for (int i = 0; i < 3; i++) pend[i] = cur_cs[i] && !(m_vld[i] && cur_addr[i] == m_addr[i]);
        if (n_rst) begin
            p_rst = 1; p_acc = 0; exp_cs = 0; exp_addr = '0; exp_addr_w = '0; p_cnt = 0;
        end else begin
            p_rst = 0; p_acc = 0;
            iss = !rom_cs && (pend[0] || pend[1] || pend[2]);
            if (pend[2] && cnt >= 32) w = 2;
            else if (pend[0])         w = 0;
            else if (pend[1])         w = 1;
            else                      w = 2;
            if (!cur_cs[2] || (iss && w == 2)) p_cnt = 0;
            else if (pend[2] && !(rom_cs && cur_ch == 2)) p_cnt = (cnt < 63) ? cnt + 1 : 63;
            else p_cnt = cnt;
            if (!rom_cs) begin
                exp_cs = iss;
                if (iss) begin
                    cur_ch = w; cur_a = cur_addr[w];
                    exp_addr   = offs(w, 0) + {2'b0, cur_addr[w]};
                    exp_addr_w = offs(w, 1) + {2'b0, cur_addr[w]};
                end
            end else begin
                p_acc = ok_drv && cs_age >= 2;
                p_ch = cur_ch; p_a = cur_a; p_d = d;
                exp_cs = !p_acc;
            end
        end
    endtask

    task automatic set_cs(bit c, bit s, bit o);
        n_cs[0] = c; n_cs[1] = s; n_cs[2] = o;
    endtask

    initial begin
        bit got;
        rst = 1; char_cs = 0; scr_cs = 0; obj_cs = 0;
        char_addr = '0; scr_addr = '0; obj_addr = '0; rom_ok = 0; rom_data = '0;
        n_rst = 1; force_ok = 0; stale_en = 0; fix_en = 0; fix_data = '0; sd_delay = 2;
        for (int i = 0; i < 3; i++) begin n_cs[i] = 0; n_addr[i] = '0; cur_cs[i] = 0; cur_addr[i] = '0; end
        p_rst = 1; p_acc = 0; p_cnt = 0; exp_cs = 0; exp_addr = '0; exp_addr_w = '0;
        cur_ch = 0; cur_a = '0; cs_age = 0; cd = 0; obj_seen = 0;

        // reset state
        repeat (3) step();
        n_rst = 0;
        step();

        // single char miss, stale ok on first cs cycle, DEADBEEF after 3 cycles
        obs_q.delete();
        set_cs(1, 0, 0); n_addr[0] = 18'h00123;
        stale_en = 1; fix_en = 1; fix_data = 32'hDEADBEEF; sd_delay = 3;
        repeat (12) step();
        chk("t1_nreq", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("t1_addr", 32'(obs_q[0]), 32'h00123);
        chk("t1_ok", 32'(char_ok), 1);
        chk("t1_data", char_data, 32'hDEADBEEF);
        stale_en = 0; fix_en = 0;

        // simultaneous misses: char > scr > obj, wrap instance gives obj at 0x00010
        obs_q.delete(); obs_w_q.delete();
        set_cs(1, 1, 1); n_addr[0] = 18'h00042; n_addr[1] = 18'h00010; n_addr[2] = 18'h00020;
        sd_delay = 2;
        repeat (25) step();
        chk("t2_nreq", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk("t2_first", 32'(obs_q[0]), 32'h00042);
            chk("t2_second", 32'(obs_q[1]), 32'h04010);
            chk("t2_third", 32'(obs_q[2]), 32'h24020);
            chk("t2_wrap", 32'(obs_w_q[2]), 32'h00010);
        end

        // obj starvation under continuous char/scr misses
        obj_seen = 0; n_addr[2] = 18'h00333; set_cs(1, 1, 1);
        for (int c = 0; c < 600 && !obj_seen; c++) begin
            for (int i = 0; i < 2; i++)
                if (m_vld[i] && m_addr[i] == cur_addr[i]) n_addr[i] = cur_addr[i] + 18'd1;
            step();
        end
        chk("t3_obj_served", 32'(obj_seen), 1);

        // drain, then scroll address moves while the read is outstanding
        set_cs(0, 0, 0);
        repeat (12) step();
        obs_q.delete();
        set_cs(0, 1, 0); n_addr[1] = 18'h00100; sd_delay = 6;
        repeat (3) step();
        n_addr[1] = 18'h00101;
        repeat (22) step();
        chk("t4_nreq", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("t4_old", 32'(obs_q[0]), 32'h04100);
            chk("t4_new", 32'(obs_q[1]), 32'h04101);
        end
        chk("t4_ok", 32'(scr_ok), 1);

        // reset during WAIT with rom_ok in the same cycle
        set_cs(1, 0, 0); n_addr[0] = 18'h00777; sd_delay = 8;
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            step();
            got = cs_age >= 2;
        end
        chk("t5_in_wait", 32'(got), 1);
        n_rst = 1; force_ok = 1;
        step();
        n_rst = 0; force_ok = 0;
        step();
        chk("t5_cs", 32'(rom_cs), 0);
        chk("t5_ok", 32'(char_ok), 0);
        chk("t5_data", char_data, 32'd0);
        repeat (14) step();

        // random traffic
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(3) == 0) n_cs[i] = $urandom_range(1);
                if ($urandom_range(3) == 0) n_addr[i] = 18'($urandom_range(3));
            end
            sd_delay = $urandom_range(1, 4);
            stale_en = $urandom_range(1);
            n_rst = ($urandom_range(63) == 0);
            step();
        end
        n_rst = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
